// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter. Frame: start, data LSB first, optional parity, stop bits.
// tx falls one cycle after the handshake. A full holding buffer drops in_ready and lets the next frame follow with no gap.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
            $error("uart_tx_param: illegal parameter value");
        end
    endgenerate

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic            PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic                   buf_full_q, buf_full_d;
    logic                   drain;
    logic                   hs;
    logic                   bit_end;

    assign in_ready = ~buf_full_q;
    assign hs       = in_valid & ~buf_full_q;
    assign bit_end  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        drain      = 1'b0;
        frame_done = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    drain   = 1'b1;
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d   = S_STOP;
                    bit_idx_d = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == STOP_LAST) begin
                        frame_done = 1'b1;
                        bit_idx_d  = '0;
                        // A waiting word starts its start bit on the very next cycle.
                        if (buf_full_q) begin
                            drain   = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drain) begin
            shift_d = buf_q;
            par_d   = (^buf_q) ^ PAR_ODD;
        end
    end

    always_comb begin
        buf_d      = hs ? in_data : buf_q;
        buf_full_d = (buf_full_q & ~drain) | hs;
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = par_q;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at four clocks per bit.
module tb_uart_tx_param;

    localparam int C = 4;
    localparam int DB  [4] = '{8, 8, 8, 7};
    localparam int PAR [4] = '{0, 2, 1, 0};
    localparam int SB  [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] vld = '0;
    logic [7:0] dat [4];
    logic [3:0] rdy, tx_w, busy_w, fd_w;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .in_data(dat[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .in_data(dat[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .in_data(dat[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));
    uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .in_data(dat[3][6:0]), .in_valid(vld[3]), .in_ready(rdy[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

    typedef struct {
        int          lane;
        logic [7:0]  word;
        logic [11:0] bits;   // expected line level per bit period, index 0 = start bit
        int          nbits;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame built from the frame rules: start, data LSB first, parity, stops.
    function automatic logic [11:0] model_bits(input int lane, input logic [7:0] w, output int n);
        logic [11:0] b;
        logic        p;
        int          k;
        b = '1;
        k = 0;
        b[k] = 1'b0; k++;
        p = 1'b0;
        for (int i = 0; i < DB[lane]; i++) begin
            b[k] = w[i]; k++;
            p = p ^ w[i];
        end
        if (PAR[lane] != 0) begin
            b[k] = (PAR[lane] == 2) ? p : ~p; k++;
        end
        for (int i = 0; i < SB[lane]; i++) begin
            b[k] = 1'b1; k++;
        end
        n = k;
        return b;
    endfunction

    task automatic check_idle(input int lane, input string tag);
        check($sformatf("%s_tx l%0d", tag, lane), 32'(tx_w[lane]), 32'd1);
        check($sformatf("%s_busy l%0d", tag, lane), 32'(busy_w[lane]), 32'd0);
        check($sformatf("%s_rdy l%0d", tag, lane), 32'(rdy[lane]), 32'd1);
        check($sformatf("%s_fd l%0d", tag, lane), 32'(fd_w[lane]), 32'd0);
    endtask

    // Called in the first cycle of a frame; walks every cycle of it.
    task automatic mon_frame(input int lane, input logic [11:0] bits, input int n, input bit buf_used);
        for (int c = 0; c < n * C; c++) begin
            check($sformatf("tx l%0d cyc%0d", lane, c), 32'(tx_w[lane]), 32'(bits[c / C]));
            check($sformatf("busy l%0d cyc%0d", lane, c), 32'(busy_w[lane]), 32'd1);
            check($sformatf("frame_done l%0d cyc%0d", lane, c), 32'(fd_w[lane]), 32'(c == n * C - 1));
            check($sformatf("in_ready l%0d cyc%0d", lane, c), 32'(rdy[lane]),
                  buf_used ? 32'(c == 0) : 32'd1);
            step();
        end
    endtask

    task automatic drive_word(input int lane, input logic [7:0] w);
        bit r;
        bit done;
        done = 1'b0;
        vld[lane] = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            r = rdy[lane];
            dat[lane] = r ? w : 8'($urandom);
            step();
            done = r;
        end
        vld[lane] = 1'b0;
        dat[lane] = 8'($urandom);
        if (!done) check($sformatf("accept_timeout l%0d", lane), 32'd0, 32'd1);
    endtask

    task automatic send_idle(input int lane, input logic [7:0] w, input logic [11:0] bits, input int n);
        check($sformatf("pre_rdy l%0d", lane), 32'(rdy[lane]), 32'd1);
        vld[lane] = 1'b1;
        dat[lane] = w;
        step();
        vld[lane] = 1'b0;
        dat[lane] = ~w;
        check($sformatf("hs_tx l%0d", lane), 32'(tx_w[lane]), 32'd1);
        check($sformatf("hs_rdy l%0d", lane), 32'(rdy[lane]), 32'd0);
        step();
        mon_frame(lane, bits, n, 1'b0);
        check_idle(lane, "post");
    endtask

    // Three words offered back to back; the third waits while junk toggles on in_data.
    task automatic send_b2b(input int lane, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [11:0] ba, bb, bc;
        int          na, nb, nc;
        ba = model_bits(lane, a, na);
        bb = model_bits(lane, b, nb);
        bc = model_bits(lane, c, nc);
        fork
            begin
                drive_word(lane, a);
                drive_word(lane, b);
                drive_word(lane, c);
            end
            begin
                step();
                check($sformatf("b2b_hs_tx l%0d", lane), 32'(tx_w[lane]), 32'd1);
                step();
                mon_frame(lane, ba, na, 1'b1);
                mon_frame(lane, bb, nb, 1'b1);
                mon_frame(lane, bc, nc, 1'b0);
                check_idle(lane, "b2b_end");
            end
        join
    endtask

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] eb;
        int          en;
        int          ln;
        logic [7:0]  w;

        vecs[0] = '{0, 8'h41, 12'h282, 10};
        vecs[1] = '{1, 8'h41, 12'h482, 11};
        vecs[2] = '{2, 8'h41, 12'h682, 11};
        vecs[3] = '{3, 8'h7F, 12'h3FE, 10};
        vecs[4] = '{0, 8'h00, 12'h200, 10};
        vecs[5] = '{1, 8'hFF, 12'h5FE, 11};
        vecs[6] = '{2, 8'h01, 12'h402, 11};
        vecs[7] = '{3, 8'h2A, 12'h354, 10};
        for (int i = 0; i < 4; i++) dat[i] = '0;

        #12;
        for (int i = 0; i < 4; i++) check_idle(i, "reset");
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            send_idle(vecs[i].lane, vecs[i].word, vecs[i].bits, vecs[i].nbits);
            step();
        end

        send_b2b(0, 8'h55, 8'hAA, 8'h3C);
        step();

        for (int i = 0; i < 12; i++) begin
            ln = int'($urandom_range(0, 3));
            w  = 8'($urandom);
            eb = model_bits(ln, w, en);
            send_idle(ln, w, eb, en);
        end
        for (int i = 0; i < 4; i++) begin
            send_b2b(i, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Asynchronous reset in the middle of a data bit.
        vld[0] = 1'b1;
        dat[0] = 8'h41;
        step();
        vld[0] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_frame_busy", 32'(busy_w[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) check_idle(i, "async_rst");
        step();
        step();
        rst = 1'b0;
        step();
        check_idle(0, "after_rst");
        send_idle(0, 8'h41, 12'h282, 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 sender.
- Serialises parallel words onto a single `tx` line with configurable bit period, data width, parity and stop bits.
- Takes words through a valid/ready handshake.
- A one-entry holding buffer allows back-to-back frames with no idle gap.
- Sits between a system-side producer (CPU/FIFO) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600 baud); legal range ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  DATA_BITS  word to transmit.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  holding buffer empty; word accepted on a clk edge where in_valid && in_ready.
- tx  output  1  serial line; idle high.
- busy  output  1  a frame is currently being shifted out.
- frame_done  output  1  one-cycle pulse in the final cycle of each frame's last stop bit.

Behaviour:
- Reset (async assert, takes effect immediately): tx=1, busy=0, in_ready=1, frame_done=0, buffer empty, FSM=IDLE, counters=0. Reset mid-frame aborts the frame; the line returns high at once.
- Frame format: start(0), data LSB first, optional parity, STOP_BITS stop bits(1).
- Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles. Every bit, start included, lasts exactly CLKS_PER_BIT cycles; no stretched start bit.
- Parity is computed on the accepted word. Even: XOR of data bits. Odd: its inverse.
- Holding buffer:
  - A handshake writes the buffer; in_ready is the negation of buffer-full.
  - in_data is captured only on the handshake edge; later changes are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START: on the edge after the buffer becomes full, the word moves to the shift register and the buffer empties. From an idle line, tx falls 1 cycle after the handshake edge.
  - START→DATA: after CLKS_PER_BIT cycles.
  - DATA→PARITY (or →STOP if PARITY=0): after DATA_BITS bit periods, tracked by a bit index counter.
  - PARITY→STOP: after one bit period.
  - STOP→START if the buffer is full at the last stop cycle (next start bit begins on the very next cycle, zero idle); otherwise STOP→IDLE.
- busy=1 in every state except IDLE.
- frame_done asserts for exactly 1 cycle per frame, including back-to-back frames.
- Simultaneous events:
  - A handshake in the same cycle the buffer drains to the shift register is legal. The buffer ends full with the new word and in_ready=0 next cycle.
  - in_valid while in_ready=0: nothing is accepted; the producer must hold.
- Bit counter is ceil(log2(CLKS_PER_BIT)) bits wide and wraps to 0 at CLKS_PER_BIT-1; it never overflows.
- Illegal parameter values are a compile-time error (generate-time check).

Test Plan:
- Reset, then CLKS_PER_BIT=4, 8N1, send 0x41 → tx = 0,1,0,0,0,0,0,1,0,1, each held 4 cycles. tx falls 1 cycle after the handshake; frame_done pulses at cycle 40; busy high for 40 cycles.
- PARITY=2 with 0x41 → parity bit 0. PARITY=1 with 0x41 → parity bit 1. Frame = 44 cycles.
- STOP_BITS=2, DATA_BITS=7, send 0x7F → start bit, seven 1s, stop high for 8 cycles; frame = 40 cycles.
- Back-to-back: present 0x55 then 0xAA with in_valid held → second start bit begins the cycle right after the first frame's last stop cycle. in_ready low while the buffer is full; frame_done pulses twice, 40 cycles apart.
- Backpressure: third word offered while busy and buffer full → in_ready=0 and the word is not accepted until the first frame ends. Changing in_data during the wait does not alter transmitted data.
- Assert rst asynchronously mid-data-bit → tx=1, busy=0, in_ready=1 the same cycle. After release, a new 0x41 frame is transmitted correctly with no remnants.
